operate_uart_tx: RTL and testbench
==================================

OPERATE_UART_TX -- requirements
Module: operate_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: uart_clk cycles per serial bit; legal range 2..65535.
REQ-002 Parameter IDLE_CODE, default 8'b1_00000_10: operate code meaning "no button"; treated as already sent after reset.
REQ-003 uart_clk  input  1: the single clock; all logic is on its rising edge.
REQ-004 rst  input  1: synchronous reset, active-high.
REQ-005 data_in  input  8: debounced operate code from the button stage; may change on any cycle.
REQ-006 tx  output  1: serial line, idle high, 8N1 frame (8E1 with REQ-030).
REQ-007 busy  output  1: high while a frame is on the line.
REQ-008 frames_sent  output  8: count of completed frames.

Function
REQ-009 The block SHALL implement FSM states IDLE, START, DATA, STOP (plus PARITY, see REQ-030).
REQ-010 Launch rule: in IDLE, when data_in != last_sent, the block SHALL capture data_in into a shift register and enter START on the next edge.
REQ-011 Launch latency: data_in differs at edge N; tx SHALL be 0 and busy SHALL be 1 after edge N+1.
REQ-012 Each state SHALL last exactly CLKS_PER_BIT cycles, timed by a bit counter wide enough for CLKS_PER_BIT-1.
REQ-013 START drives tx=0; DATA drives bits D0..D7 LSB first (8 bit-times); STOP drives tx=1.
REQ-014 The byte on the line SHALL be the value captured at launch; later data_in changes SHALL NOT corrupt it.
REQ-015 last_sent SHALL update to the captured byte at launch.
REQ-016 At the end of STOP the FSM SHALL return to IDLE and increment frames_sent by 1, modulo 256 (255 -> 0).
REQ-017 busy SHALL be 1 from the first START cycle through the last STOP cycle, and 0 in IDLE.
REQ-018 Changes to data_in during a frame SHALL be coalesced: only the value present in the first IDLE cycle is compared, so intermediate codes are dropped.
REQ-019 Back-to-back frames: if a compare fires in the first IDLE cycle, the next START SHALL begin one cycle after STOP ends (one idle-high cycle minimum).
REQ-020 If data_in returns to last_sent before the frame ends, no further frame SHALL be sent.
REQ-021 tx SHALL be driven from a register, with no combinational path from data_in.

Reset
REQ-022 When rst=1 at an edge: state=IDLE, tx=1, busy=0, frames_sent=0, bit counter=0, shift register=0, last_sent=IDLE_CODE.
REQ-023 A reset mid-frame SHALL abort the frame: tx=1 after that edge, and the partial frame is not counted.
REQ-024 After reset release, a frame SHALL launch only if data_in != IDLE_CODE.

Configuration
REQ-030 Macro OPERATE_UART_TX_PARITY_EN defined: the FSM SHALL insert a PARITY state of CLKS_PER_BIT cycles between DATA and STOP, driving the even parity bit (XOR of D0..D7); frame = 11 bit-times.
REQ-031 Macro OPERATE_UART_TX_PARITY_EN undefined: there SHALL be no PARITY state and no parity logic; frame = 10 bit-times.

Verification (CLKS_PER_BIT=4)
REQ-040 Reset hold: assert rst for 3 cycles with data_in=8'h82 (IDLE_CODE), then run 100 cycles -> tx=1, busy=0, frames_sent=0 throughout.
REQ-041 Single frame: data_in 8'h82 -> 8'h86 -> tx low one cycle later, bit sequence 0,0,1,1,0,0,0,0,1 then stop 1, busy high 40 cycles, frames_sent=1.
REQ-042 Coalescing: launch 8'h86, then during DATA drive 8'h8A followed by 8'h92 -> exactly one further frame carrying 8'h92, frames_sent=2.
REQ-043 Abort: assert rst during data bit 3 -> tx=1 and busy=0 on the next cycle, frames_sent=0; after release with 8'h86 still applied, a full new frame is sent.
REQ-044 Parity (macro defined): send 8'h86 -> parity bit 1 before stop, busy high 44 cycles.
REQ-045 Wrap: toggle data_in between 8'h86 and 8'h82 for 256 frames -> frames_sent goes 255 -> 0 with no glitch on tx.

Source files
------------

// File: rtl/operate_uart_tx.sv
// operate_uart_tx: serialises operate codes from the button stage onto a UART line.
// A frame is sent whenever the debounced code differs from the last code sent.
// Frame: start bit, D0..D7 LSB first, stop bit (8N1).
// Optional feature macro: OPERATE_UART_TX_PARITY_EN adds an even parity bit
// between D7 and stop (8E1).
module operate_uart_tx #(
  parameter int          CLKS_PER_BIT = 16,
  parameter logic [7:0]  IDLE_CODE    = 8'b1_00000_10
) (
  input  logic       uart_clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  output logic       tx,
  output logic       busy,
  output logic [7:0] frames_sent
);

  // Bit timer only has to reach CLKS_PER_BIT-1; CLKS_PER_BIT >= 2 keeps this >= 1.
  localparam int CNT_W = $clog2(CLKS_PER_BIT);

`ifdef OPERATE_UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t           state_reg;
  logic [CNT_W-1:0] bit_cnt_reg;
  logic [2:0]       bit_idx_reg;
  logic [7:0]       shift_reg;
  logic [7:0]       last_sent_reg;
  logic             tx_reg;
  logic             busy_reg;
  logic [7:0]       frames_sent_reg;
  logic             bit_end;

  // The current bit-time ends on this cycle.
  assign bit_end = (bit_cnt_reg == CNT_W'(CLKS_PER_BIT - 1));

  // Frame sequencer; tx and busy are registered so data_in never reaches the line combinationally.
  always_ff @(posedge uart_clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      bit_cnt_reg     <= '0;
      bit_idx_reg     <= '0;
      shift_reg       <= '0;
      last_sent_reg   <= IDLE_CODE;
      tx_reg          <= 1'b1;
      busy_reg        <= 1'b0;
      frames_sent_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          bit_cnt_reg <= '0;
          bit_idx_reg <= '0;
          tx_reg      <= 1'b1;
          busy_reg    <= 1'b0;
          // Only the code present now is compared; anything seen mid-frame was dropped.
          if (data_in != last_sent_reg) begin
            shift_reg     <= data_in;
            last_sent_reg <= data_in;
            state_reg     <= START;
            tx_reg        <= 1'b0;
            busy_reg      <= 1'b1;
          end
        end

        START: begin
          if (bit_end) begin
            bit_cnt_reg <= '0;
            bit_idx_reg <= '0;
            state_reg   <= DATA;
            tx_reg      <= shift_reg[0];
          end else begin
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
          end
        end

        DATA: begin
          if (bit_end) begin
            bit_cnt_reg <= '0;
            if (bit_idx_reg == 3'd7) begin
`ifdef OPERATE_UART_TX_PARITY_EN
              // last_sent_reg holds the byte captured at launch, untouched by shifting.
              state_reg <= PARITY;
              tx_reg    <= ^last_sent_reg;
`else
              state_reg <= STOP;
              tx_reg    <= 1'b1;
`endif
            end else begin
              bit_idx_reg <= bit_idx_reg + 3'd1;
              shift_reg   <= {1'b0, shift_reg[7:1]};
              tx_reg      <= shift_reg[1];
            end
          end else begin
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
          end
        end

`ifdef OPERATE_UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            bit_cnt_reg <= '0;
            state_reg   <= STOP;
            tx_reg      <= 1'b1;
          end else begin
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
          end
        end
`endif

        STOP: begin
          if (bit_end) begin
            bit_cnt_reg     <= '0;
            state_reg       <= IDLE;
            busy_reg        <= 1'b0;
            frames_sent_reg <= frames_sent_reg + 8'd1;
          end else begin
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
          end
        end

        default: begin
          state_reg <= IDLE;
          tx_reg    <= 1'b1;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign tx          = tx_reg;
  assign busy        = busy_reg;
  assign frames_sent = frames_sent_reg;

endmodule

// File: tb/tb_operate_uart_tx.sv
// Directed bench for operate_uart_tx with CLKS_PER_BIT=4.
// Build with OPERATE_UART_TX_PARITY_EN defined to exercise the 8E1 frame.
module tb_operate_uart_tx;

  localparam int C = 4;
`ifdef OPERATE_UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic       uart_clk = 1'b0;
  logic       rst      = 1'b1;
  logic [7:0] data_in  = 8'h82;
  logic       tx;
  logic       busy;
  logic [7:0] frames_sent;

  int total = 0;
  int bad   = 0;

  always #5 uart_clk = ~uart_clk;

  operate_uart_tx #(.CLKS_PER_BIT(C), .IDLE_CODE(8'h82)) dut (
    .uart_clk    (uart_clk),
    .rst         (rst),
    .data_in     (data_in),
    .tx          (tx),
    .busy        (busy),
    .frames_sent (frames_sent)
  );

  // Expected line bits in time order: start, D0..D7, [parity], stop; unused slots are 1.
  function automatic logic [10:0] expected_frame(input logic [7:0] d);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
`ifdef OPERATE_UART_TX_PARITY_EN
    f[9]   = ^d;
`endif
    return f;
  endfunction

  task automatic drive_data(input logic [7:0] d);
    @(posedge uart_clk);
    #1 data_in = d;
  endtask

  task automatic apply_reset(input int n);
    @(posedge uart_clk);
    #1 rst = 1'b1;
    repeat (n) @(posedge uart_clk);
    #1 rst = 1'b0;
  endtask

  // Waits (bounded) for a start bit, then records one frame sampled at negedges.
  // Returns at the first negedge with busy low.
  task automatic capture_frame(input int bound, output logic [10:0] bits, output int blen,
                               output int waited, output bit found, output bit glitch);
    bits = '1; blen = 0; waited = 0; found = 1'b0; glitch = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (tx === 1'b0) begin
        found = 1'b1;
        break;
      end
      @(negedge uart_clk);
      waited++;
    end
    if (found) begin
      for (int c = 0; c < FRAME_BITS * C + 4; c++) begin
        if (busy !== 1'b1) break;
        blen++;
        if (c / C < FRAME_BITS) begin
          if (c % C == 0) bits[c / C] = tx;
          else if (tx !== bits[c / C]) glitch = 1'b1;
        end
        @(negedge uart_clk);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; data_in = 8'h82;
    repeat (3) @(posedge uart_clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge uart_clk);
      total++;
      if (tx !== 1'b1 || busy !== 1'b0 || frames_sent !== 8'd0) begin
        bad++;
        $display("FAIL reset_hold cycle=%0d tx=%b busy=%b frames=%0d required tx=1 busy=0 frames=0",
                 i, tx, busy, frames_sent);
      end
    end
    $display("test_reset: 100 idle cycles checked");
  endtask

  task automatic test_single_frame;
    logic [10:0] bits; int blen, waited; bit found, glitch;
    drive_data(8'h86);
    @(negedge uart_clk);
    total++;
    if (tx !== 1'b1) begin
      bad++; $display("FAIL launch_early tx=%b required 1", tx);
    end
    @(negedge uart_clk);
    total++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL launch_latency tx=%b busy=%b required tx=0 busy=1", tx, busy);
    end
    capture_frame(4, bits, blen, waited, found, glitch);
    total++;
    if (!found || bits !== expected_frame(8'h86)) begin
      bad++; $display("FAIL single_bits found=%b got=%b required=%b", found, bits, expected_frame(8'h86));
    end
    total++;
    if (blen != FRAME_BITS * C || glitch) begin
      bad++; $display("FAIL single_busy_len got=%0d glitch=%b required=%0d", blen, glitch, FRAME_BITS * C);
    end
    total++;
    if (frames_sent !== 8'd1 || busy !== 1'b0 || tx !== 1'b1) begin
      bad++; $display("FAIL single_end frames=%0d busy=%b tx=%b required 1 0 1", frames_sent, busy, tx);
    end
    $display("test_single_frame: bits=%b busy_len=%0d frames=%0d", bits, blen, frames_sent);
  endtask

  task automatic test_coalesce;
    logic [10:0] bits; int blen, waited, extra; bit found, glitch;
    @(posedge uart_clk);
    #1 rst = 1'b1; data_in = 8'h86;
    repeat (3) @(posedge uart_clk);
    #1 rst = 1'b0;
    fork
      capture_frame(10, bits, blen, waited, found, glitch);
      begin
        repeat (12) @(posedge uart_clk);
        #1 data_in = 8'h8A;
        repeat (8) @(posedge uart_clk);
        #1 data_in = 8'h92;
      end
    join
    total++;
    if (!found || bits !== expected_frame(8'h86) || glitch) begin
      bad++; $display("FAIL coalesce_first got=%b required=%b glitch=%b", bits, expected_frame(8'h86), glitch);
    end
    capture_frame(4, bits, blen, waited, found, glitch);
    total++;
    if (!found || waited != 1) begin
      bad++; $display("FAIL back_to_back_gap found=%b idle_cycles=%0d required 1", found, waited);
    end
    total++;
    if (bits !== expected_frame(8'h92) || glitch) begin
      bad++; $display("FAIL coalesce_second got=%b required=%b glitch=%b", bits, expected_frame(8'h92), glitch);
    end
    extra = 0;
    for (int i = 0; i < 60; i++) begin
      if (busy !== 1'b0 || tx !== 1'b1) extra++;
      @(negedge uart_clk);
    end
    total++;
    if (extra != 0 || frames_sent !== 8'd2) begin
      bad++; $display("FAIL coalesce_count busy_cycles=%0d frames=%0d required 0 and 2", extra, frames_sent);
    end
    $display("test_coalesce: second=%b frames=%0d", bits, frames_sent);
  endtask

  task automatic test_abort;
    logic [10:0] bits; int blen, waited; bit found, glitch;
    drive_data(8'h86);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge uart_clk);
      if (tx === 1'b0) begin found = 1'b1; break; end
    end
    total++;
    if (!found) begin
      bad++; $display("FAIL abort_launch tx=%b required start bit", tx);
    end
    repeat (17) @(negedge uart_clk);
    total++;
    if (busy !== 1'b1 || tx !== 1'b0) begin
      bad++; $display("FAIL abort_mid_bit3 busy=%b tx=%b required 1 0", busy, tx);
    end
    @(posedge uart_clk);
    #1 rst = 1'b1;
    @(posedge uart_clk);
    @(negedge uart_clk);
    total++;
    if (tx !== 1'b1 || busy !== 1'b0 || frames_sent !== 8'd0) begin
      bad++; $display("FAIL abort_reset tx=%b busy=%b frames=%0d required 1 0 0", tx, busy, frames_sent);
    end
    rst = 1'b0;
    capture_frame(6, bits, blen, waited, found, glitch);
    total++;
    if (!found || bits !== expected_frame(8'h86) || blen != FRAME_BITS * C || glitch) begin
      bad++; $display("FAIL abort_resend got=%b len=%0d required=%b len=%0d",
                      bits, blen, expected_frame(8'h86), FRAME_BITS * C);
    end
    total++;
    if (frames_sent !== 8'd1) begin
      bad++; $display("FAIL abort_count frames=%0d required 1", frames_sent);
    end
    $display("test_abort: resend=%b frames=%0d", bits, frames_sent);
  endtask

  task automatic test_wrap;
    logic [10:0] bits; int blen, waited; bit found, glitch;
    logic [7:0] d;
    logic [7:0] want;
    @(posedge uart_clk);
    #1 rst = 1'b1; data_in = 8'h82;
    repeat (3) @(posedge uart_clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 256; k++) begin
      d    = (k % 2 == 0) ? 8'h86 : 8'h82;
      want = 8'(k + 1);
      drive_data(d);
      capture_frame(6, bits, blen, waited, found, glitch);
      total++;
      if (!found || bits !== expected_frame(d) || glitch || blen != FRAME_BITS * C) begin
        bad++; $display("FAIL wrap_frame k=%0d got=%b len=%0d glitch=%b required=%b len=%0d",
                        k, bits, blen, glitch, expected_frame(d), FRAME_BITS * C);
      end
      total++;
      if (frames_sent !== want) begin
        bad++; $display("FAIL wrap_count k=%0d frames=%0d required %0d", k, frames_sent, want);
      end
    end
    $display("test_wrap: 256 frames, frames_sent=%0d", frames_sent);
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_coalesce();
    test_abort();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
